// File: rtl/twos_comp_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : twos_comp_serial_if
// Brief    : Operand/result handshake bundle for the bit-serial converter.
// Revision : 1.0
// ============================================================================
interface twos_comp_serial_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             busy;

  // Producer/consumer side.
  modport master (
    output in_valid, a, mode, out_ready,
    input  in_ready, out_valid, result, ovf, busy
  );

  // Converter side.
  modport slave (
    input  in_valid, a, mode, out_ready,
    output in_ready, out_valid, result, ovf, busy
  );
endinterface
`default_nettype wire

// File: rtl/twos_comp_serial.sv
`default_nettype none
// ============================================================================
// Module   : twos_comp_serial
// Brief    : Bit-serial two's-complement converter (negate/abs/SM<->2C),
//            one bit per clock, LSB first, with valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module twos_comp_serial #(
  parameter int WIDTH = 4
) (
  input wire               clk,
  input wire               reset,
  twos_comp_serial_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0]    c_last      = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_min       = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [1:0]       c_mode_neg  = 2'b00;
  localparam logic [1:0]       c_mode_sm2c = 2'b10;
  localparam logic [1:0]       c_mode_2csm = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_seen;
  logic             r_neg;
  logic             r_msb;
  logic             r_ovf;
  logic [1:0]       r_mode;

  logic             w_accept;
  logic             w_last;
  logic             w_x;
  logic             w_bit;
  logic             w_neg_in;
  logic             w_ovf_in;
  logic [WIDTH-1:0] w_load;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        // Output handshake only; a waiting operand is taken back in IDLE.
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // ------------------------------------------------------ accept decode
  assign w_accept = w_in_ready && bus.in_valid;
  assign w_neg_in = (bus.mode == c_mode_neg) ? 1'b1 : bus.a[WIDTH-1];
  assign w_ovf_in = (bus.mode != c_mode_sm2c) && (bus.a == c_min);
  // Sign-magnitude input drops its sign bit before the magnitude is negated.
  assign w_load   = (bus.mode == c_mode_sm2c) ? {1'b0, bus.a[WIDTH-2:0]} : bus.a;

  // ------------------------------------------------------ serial datapath
  assign w_last = (r_cnt == c_last);
  assign w_x    = r_shift[0];

  always_comb begin
    w_bit = r_neg ? (r_seen ? ~w_x : w_x) : w_x;
    // Sign-magnitude output keeps the operand's sign in the top bit.
    if (w_last && (r_mode == c_mode_2csm)) begin
      w_bit = r_msb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift  <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_seen   <= 1'b0;
      r_neg    <= 1'b0;
      r_msb    <= 1'b0;
      r_ovf    <= 1'b0;
      r_mode   <= 2'b00;
    end else begin
      if (w_accept) begin
        r_shift <= w_load;
        r_mode  <= bus.mode;
        r_neg   <= w_neg_in;
        r_msb   <= bus.a[WIDTH-1];
        r_ovf   <= w_ovf_in;
        r_seen  <= 1'b0;
        r_cnt   <= '0;
      end else if (w_busy) begin
        r_shift  <= r_shift >> 1;
        r_seen   <= r_seen | w_x;
        r_cnt    <= r_cnt + 1'b1;
        r_result <= {w_bit, r_result[WIDTH-1:1]};
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.result    = r_result;
  assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_twos_comp_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_twos_comp_serial
// Brief    : Directed and model-based checks of twos_comp_serial (WIDTH 4, 8).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_twos_comp_serial;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  twos_comp_serial_if #(.WIDTH(4)) b4 ();
  twos_comp_serial_if #(.WIDTH(8)) b8 ();

  twos_comp_serial #(.WIDTH(4)) u4 (.clk(clk), .reset(reset), .bus(b4));
  twos_comp_serial #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(b8));

  // Arithmetic reference for the 8-bit unit (not bit-serial).
  function automatic void model8(input logic [7:0] a, input logic [1:0] m,
                                 output logic [7:0] r, output logic o);
    logic [7:0] neg;
    logic [7:0] mag;
    neg = -a;
    mag = {1'b0, a[6:0]};
    o   = (a == 8'h80) && (m != 2'b10);
    case (m)
      2'b00:   r = neg;
      2'b01:   r = a[7] ? neg : a;
      2'b10:   r = a[7] ? 8'(-mag) : mag;
      default: r = a[7] ? {1'b1, neg[6:0]} : a;
    endcase
  endfunction

  // lat counts rising edges from the accept edge (inclusive) to out_valid.
  task automatic do_op4(input logic [3:0] a, input logic [1:0] m,
                        output logic [3:0] res, output logic ovf,
                        output int lat, output int bcnt);
    int n;
    n = 0;
    while (!b4.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    b4.a = a; b4.mode = m; b4.in_valid = 1'b1;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    lat = 1; bcnt = 0;
    while (!b4.out_valid && lat < 40) begin
      if (b4.busy) bcnt++;
      @(posedge clk); #1; lat++;
    end
    res = b4.result; ovf = b4.ovf;
    b4.out_ready = 1'b1;
    @(posedge clk); #1;
    b4.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_vec++; if (b4.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", b4.in_ready); end
    n_vec++; if (b4.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", b4.out_valid); end
    n_vec++; if (b4.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", b4.busy); end
    n_vec++; if (b4.result !== 4'b0000) begin n_err++; $display("FAIL reset_result: got %b want 0000", b4.result); end
    n_vec++; if (b4.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", b4.ovf); end
    n_vec++; if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.result !== 8'h00)
      begin n_err++; $display("FAIL reset_w8: got ready=%b valid=%b result=%h want 1 0 00", b8.in_ready, b8.out_valid, b8.result); end
  endtask

  task automatic test_negate;
    logic [3:0] res; logic ovf; int lat; int bcnt;
    do_op4(4'b0101, 2'b00, res, ovf, lat, bcnt);
    n_vec++; if (res !== 4'b1011 || ovf !== 1'b0) begin n_err++; $display("FAIL negate_0101: got %b ovf %b want 1011 ovf 0", res, ovf); end
    n_vec++; if (lat != 5) begin n_err++; $display("FAIL negate_latency: got %0d edges want 5", lat); end
    n_vec++; if (bcnt != 4) begin n_err++; $display("FAIL negate_busy_cycles: got %0d want 4", bcnt); end
  endtask

  task automatic test_modes;
    logic [3:0] va [8] = '{4'b1000, 4'b1000, 4'b1101, 4'b0011, 4'b1101, 4'b1000, 4'b1011, 4'b0110};
    logic [1:0] vm [8] = '{2'b00,   2'b01,   2'b01,   2'b01,   2'b10,   2'b10,   2'b11,   2'b11};
    logic [3:0] vr [8] = '{4'b1000, 4'b1000, 4'b0011, 4'b0011, 4'b1011, 4'b0000, 4'b1101, 4'b0110};
    logic       vo [8] = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b0};
    logic [3:0] res; logic ovf; int lat; int bcnt;
    for (int i = 0; i < 8; i++) begin
      do_op4(va[i], vm[i], res, ovf, lat, bcnt);
      n_vec++;
      if (res !== vr[i] || ovf !== vo[i] || lat != 5 || bcnt != 4) begin
        n_err++;
        $display("FAIL mode%b_a%b: got %b ovf %b lat %0d busy %0d want %b ovf %b lat 5 busy 4",
                 vm[i], va[i], res, ovf, lat, bcnt, vr[i], vo[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    b4.a = 4'b0110; b4.mode = 2'b00; b4.in_valid = 1'b1;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    n = 0;
    while (!b4.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_vec++; if (b4.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_done_timeout: got out_valid %b want 1", b4.out_valid); end
    for (int i = 0; i < 10; i++) begin
      b4.in_valid = i[0]; b4.a = 4'(i); b4.mode = 2'(i);
      @(posedge clk); #1;
      n_vec++;
      if (b4.result !== 4'b1010 || b4.ovf !== 1'b0 || b4.in_ready !== 1'b0 || b4.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got result %b ovf %b ready %b valid %b want 1010 0 0 1",
                 i, b4.result, b4.ovf, b4.in_ready, b4.out_valid);
      end
    end
    // Output handshake with a competing operand: only the handshake happens.
    b4.in_valid = 1'b1; b4.a = 4'b0001; b4.mode = 2'b00; b4.out_ready = 1'b1;
    @(posedge clk); #1;
    b4.out_ready = 1'b0; b4.in_valid = 1'b0;
    n_vec++;
    if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 || b4.busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: got ready %b valid %b busy %b want 1 0 0", b4.in_ready, b4.out_valid, b4.busy);
    end
  endtask

  task automatic test_reset_abort;
    logic [3:0] res; logic ovf; int lat; int bcnt; int spur;
    b4.a = 4'b0101; b4.mode = 2'b00; b4.in_valid = 1'b1;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 || b4.busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_async: got ready %b valid %b busy %b want 1 0 0", b4.in_ready, b4.out_valid, b4.busy);
    end
    n_vec++; if (b4.result !== 4'b0000 || b4.ovf !== 1'b0) begin n_err++; $display("FAIL abort_result: got %b ovf %b want 0000 0", b4.result, b4.ovf); end
    @(posedge clk); #1;
    reset = 1'b0;
    spur = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (b4.out_valid !== 1'b0) spur++;
    end
    n_vec++; if (spur != 0) begin n_err++; $display("FAIL abort_spurious_valid: got %0d cycles want 0", spur); end
    do_op4(4'b0001, 2'b00, res, ovf, lat, bcnt);
    n_vec++;
    if (res !== 4'b1111 || ovf !== 1'b0 || lat != 5 || bcnt != 4) begin
      n_err++;
      $display("FAIL abort_recover: got %b ovf %b lat %0d busy %0d want 1111 0 5 4", res, ovf, lat, bcnt);
    end
  endtask

  task automatic test_width8;
    logic [7:0] a; logic [1:0] m; logic [7:0] er; logic eo; int lat;
    // 8'h80 negate is the overflow corner.
    b8.a = 8'h80; b8.mode = 2'b00; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    lat = 1;
    while (!b8.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    n_vec++;
    if (b8.result !== 8'h80 || b8.ovf !== 1'b1 || lat != 9) begin
      n_err++;
      $display("FAIL w8_min: got %h ovf %b lat %0d want 80 1 9", b8.result, b8.ovf, lat);
    end
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    // Stream at maximum cadence with out_ready held high.
    for (int k = 0; k < 1000; k++) begin
      a = (k % 16 == 0) ? 8'h80 : (k % 16 == 1) ? 8'h00 : 8'($urandom);
      m = 2'($urandom);
      model8(a, m, er, eo);
      n_vec++; if (b8.in_ready !== 1'b1) begin n_err++; $display("FAIL w8_ready_%0d: got %b want 1", k, b8.in_ready); end
      b8.a = a; b8.mode = m; b8.in_valid = 1'b1;
      @(posedge clk); #1;
      b8.in_valid = 1'b0;
      lat = 1;
      while (!b8.out_valid && lat < 40) begin
        @(posedge clk); #1; lat++;
      end
      n_vec++;
      if (b8.result !== er || b8.ovf !== eo || lat != 9) begin
        n_err++;
        $display("FAIL w8_rand_%0d mode %b a %h: got %h ovf %b lat %0d want %h ovf %b lat 9",
                 k, m, a, b8.result, b8.ovf, lat, er, eo);
      end
      @(posedge clk); #1;
    end
    b8.out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    b4.in_valid = 1'b0; b4.a = '0; b4.mode = 2'b00; b4.out_ready = 1'b0;
    b8.in_valid = 1'b0; b8.a = '0; b8.mode = 2'b00; b8.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b0;
    @(posedge clk); #1;
    test_negate;
    test_modes;
    test_backpressure;
    test_reset_abort;
    test_width8;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
